// File: rtl/dp_pkg.sv
// Shared widths and ALU function codes for the 16-bit datapath.
package dp_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_func_e;

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU; add and subtract share one adder (sub = x + ~y + 1).
module alu16
    import dp_pkg::*;
(
    input  alu_func_e         func,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] z,
    output logic              carry,
    output logic              overflow
);

    logic              is_sub;
    logic [WORD_W-1:0] y_eff;
    logic [WORD_W:0]   sum;

    assign is_sub = (func == ALU_SUB);
    assign y_eff  = is_sub ? ~y : y;
    assign sum    = {1'b0, x} + {1'b0, y_eff} + {{WORD_W{1'b0}}, is_sub};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        z        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        unique case (func)
            ALU_ADD, ALU_SUB: begin
                z        = sum[WORD_W-1:0];
                carry    = sum[WORD_W];
                overflow = (x[WORD_W-1] == y_eff[WORD_W-1]) &&
                           (sum[WORD_W-1] != x[WORD_W-1]);
            end
            ALU_AND: z = x & y;
            ALU_OR:  z = x | y;
            ALU_XOR: z = x ^ y;
            ALU_NOT: z = ~x;
            ALU_SHL: begin
                z     = {x[WORD_W-2:0], 1'b0};
                carry = x[WORD_W-1];
            end
            ALU_SHR: begin
                z     = {1'b0, x[WORD_W-1:1]};
                carry = x[0];
            end
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/datapath_code.sv
// Single-cycle 16-bit datapath: IR/PC, register file, X/Y/Z buses, ALU and data memory.
// All transfers are steered by strobes from an external controller.
module datapath_code
    import dp_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] inswrite_line,
    input  logic [WORD_W-1:0] insadd_line,
    input  logic              readins,
    input  logic              writeins,
    input  logic              TopID,
    input  logic              Trans1PC,
    input  logic              Trans2PC,
    input  logic              ldPC,
    input  logic              read1,
    input  logic              read2,
    input  logic              write,
    input  logic              TransX1,
    input  logic              TransX2,
    input  logic              TransX3,
    input  logic              TransY1,
    input  logic              TransY2,
    input  logic              TransY3,
    input  logic [2:0]        func_select,
    input  logic              Trans_ALU_Z,
    input  logic              TransYZ,
    input  logic              TDZ,
    input  logic              readData,
    input  logic              writeData,
    output logic [WORD_W-1:0] ins_out,
    output logic              Zin,
    output logic              Vin,
    output logic              Sin,
    output logic              Cin
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    logic [WORD_W-1:0] imem [IMEM_DEPTH];
    logic [WORD_W-1:0] dmem [DMEM_DEPTH];
    logic [WORD_W-1:0] regs [NUM_REGS];
    logic [WORD_W-1:0] pc;

    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [WORD_W-1:0]     sext5, sext8, sext11;
    logic [WORD_W-1:0]     a_bus, b_bus, x_bus, y_bus, z_bus;
    logic [WORD_W-1:0]     alu_z, dmem_rd;
    logic [IMEM_AW-1:0]    imem_raddr;
    logic [DMEM_AW-1:0]    dmem_addr;
    logic                  alu_carry, alu_ovf;
    logic                  unused_addr_bits;

    assign rd     = ins_out[10:8];
    assign rs1    = ins_out[7:5];
    assign rs2    = ins_out[4:2];
    assign sext5  = {{(WORD_W-5){ins_out[4]}},   ins_out[4:0]};
    assign sext8  = {{(WORD_W-8){ins_out[7]}},   ins_out[7:0]};
    assign sext11 = {{(WORD_W-11){ins_out[10]}}, ins_out[10:0]};

    assign imem_raddr       = TopID ? pc[IMEM_AW-1:0] : insadd_line[IMEM_AW-1:0];
    assign unused_addr_bits = ^insadd_line[WORD_W-1:IMEM_AW];

    // NOTE: memories carry no reset; only architectural state (PC, IR, registers) is cleared.
    always_ff @(posedge clk) begin
        if (writeins) imem[insadd_line[IMEM_AW-1:0]] <= inswrite_line;
        if (writeData) dmem[dmem_addr] <= y_bus;
    end

    // IR samples the pre-edge array, so a same-address write on this edge is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ins_out <= '0;
        else if (readins) ins_out <= imem[imem_raddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (write) begin
            regs[rd] <= z_bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (ldPC) begin
            if (Trans1PC)      pc <= pc + 1'b1;
            else if (Trans2PC) pc <= z_bus;
        end
    end

    assign a_bus = read1 ? regs[rs1] : '0;
    assign b_bus = read2 ? regs[rs2] : '0;

    always_comb begin
        x_bus = '0;
        if (TransX1)      x_bus = a_bus;
        else if (TransX2) x_bus = pc;
        else if (TransX3) x_bus = sext5;

        y_bus = '0;
        if (TransY1)      y_bus = b_bus;
        else if (TransY2) y_bus = sext8;
        else if (TransY3) y_bus = sext11;

        z_bus = '0;
        if (Trans_ALU_Z)  z_bus = alu_z;
        else if (TransYZ) z_bus = y_bus;
        else if (TDZ)     z_bus = dmem_rd;
    end

    assign dmem_addr = x_bus[DMEM_AW-1:0];
    assign dmem_rd   = readData ? dmem[dmem_addr] : '0;

    alu16 u_alu (
        .func     (alu_func_e'(func_select)),
        .x        (x_bus),
        .y        (y_bus),
        .z        (alu_z),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    assign Zin = (alu_z == '0);
    assign Sin = alu_z[WORD_W-1];
    assign Cin = alu_carry;
    assign Vin = alu_ovf;

endmodule

// File: tb/tb_datapath_code.sv
// Directed bench for datapath_code; register contents are read back by shifting
// them left through the ALU and sampling the carry flag bit by bit.
module tb_datapath_code;
    import dp_pkg::*;

    logic        clk, rst;
    logic [15:0] inswrite_line, insadd_line;
    logic        readins, writeins, TopID, Trans1PC, Trans2PC, ldPC;
    logic        read1, read2, write;
    logic        TransX1, TransX2, TransX3, TransY1, TransY2, TransY3;
    logic [2:0]  func_select;
    logic        Trans_ALU_Z, TransYZ, TDZ, readData, writeData;
    logic [15:0] ins_out;
    logic        Zin, Vin, Sin, Cin;

    int errors = 0;
    int checks = 0;

    datapath_code dut (
        .clk(clk), .rst(rst),
        .inswrite_line(inswrite_line), .insadd_line(insadd_line),
        .readins(readins), .writeins(writeins), .TopID(TopID),
        .Trans1PC(Trans1PC), .Trans2PC(Trans2PC), .ldPC(ldPC),
        .read1(read1), .read2(read2), .write(write),
        .TransX1(TransX1), .TransX2(TransX2), .TransX3(TransX3),
        .TransY1(TransY1), .TransY2(TransY2), .TransY3(TransY3),
        .func_select(func_select),
        .Trans_ALU_Z(Trans_ALU_Z), .TransYZ(TransYZ), .TDZ(TDZ),
        .readData(readData), .writeData(writeData),
        .ins_out(ins_out), .Zin(Zin), .Vin(Vin), .Sin(Sin), .Cin(Cin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        alu_func_e   f;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [3:0]  cvsz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        readins = 0; writeins = 0; TopID = 0; Trans1PC = 0; Trans2PC = 0; ldPC = 0;
        read1 = 0; read2 = 0; write = 0;
        TransX1 = 0; TransX2 = 0; TransX3 = 0; TransY1 = 0; TransY2 = 0; TransY3 = 0;
        func_select = ALU_ADD; Trans_ALU_Z = 0; TransYZ = 0; TDZ = 0;
        readData = 0; writeData = 0;
    endtask

    function automatic logic [15:0] flags();
        return {12'h000, Cin, Vin, Sin, Zin};
    endfunction

    task automatic write_imem(input logic [15:0] addr, input logic [15:0] val);
        clear_ctrl();
        writeins = 1; insadd_line = addr; inswrite_line = val;
        tick();
        writeins = 0;
    endtask

    task automatic fetch(input logic top, input logic [15:0] addr);
        clear_ctrl();
        readins = 1; TopID = top; insadd_line = addr;
        tick();
        readins = 0;
    endtask

    task automatic set_ir(input logic [15:0] val);
        write_imem(16'd63, val);
        fetch(1'b0, 16'd63);
    endtask

    task automatic load_imm8(input logic [2:0] r, input logic [7:0] imm);
        set_ir({5'b0, r, imm});
        TransY2 = 1; TransYZ = 1; write = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic alu_rr(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                          input alu_func_e f, output logic [15:0] fl);
        set_ir({5'b0, rd, rs1, rs2, 2'b00});
        read1 = 1; read2 = 1; TransX1 = 1; TransY1 = 1;
        func_select = f; Trans_ALU_Z = 1; write = 1;
        #1 fl = flags();
        tick();
        clear_ctrl();
    endtask

    // Builds an arbitrary word nibble by nibble; R7 is scratch.
    task automatic load_const(input logic [2:0] r, input logic [15:0] val);
        logic [15:0] fl;
        load_imm8(r, 8'h00);
        for (int n = 3; n >= 0; n--) begin
            for (int s = 0; s < 4; s++) alu_rr(r, r, r, ALU_SHL, fl);
            load_imm8(3'd7, {4'h0, val[n*4 +: 4]});
            alu_rr(r, r, 3'd7, ALU_OR, fl);
        end
    endtask

    // Destructive: the register is left holding zero.
    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        set_ir({5'b0, r, r, 5'b0});
        read1 = 1; TransX1 = 1; func_select = ALU_SHL; Trans_ALU_Z = 1; write = 1;
        for (int i = 15; i >= 0; i--) begin
            #1 val[i] = Cin;
            tick();
        end
        clear_ctrl();
    endtask

    initial begin
        logic [15:0] v, fl;

        vecs[0]  = '{ALU_ADD, 16'h0008, 16'h0001, 16'h0009, 4'b0000};
        vecs[1]  = '{ALU_SUB, 16'h0419, 16'h0001, 16'h0418, 4'b1000};
        vecs[2]  = '{ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
        vecs[3]  = '{ALU_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b1001};
        vecs[4]  = '{ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
        vecs[5]  = '{ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
        vecs[6]  = '{ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010};
        vecs[7]  = '{ALU_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
        vecs[8]  = '{ALU_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0010};
        vecs[9]  = '{ALU_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001};
        vecs[10] = '{ALU_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0010};
        vecs[11] = '{ALU_SHL, 16'h8001, 16'h0000, 16'h0002, 4'b1000};
        vecs[12] = '{ALU_SHR, 16'h8001, 16'h0000, 16'h4000, 4'b1000};
        vecs[13] = '{ALU_SHR, 16'h0002, 16'h0000, 16'h0001, 4'b0000};
        vecs[14] = '{ALU_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1101};

        // Reset state: IR cleared, idle buses give 0+0 so only Zin is set.
        rst = 0; inswrite_line = '0; insadd_line = '0;
        clear_ctrl();
        #12;
        check("reset ins_out", ins_out, 16'h0000);
        check("reset flags", flags(), 16'h0001);
        rst = 1;
        tick();

        // Instruction memory load and fetch.
        write_imem(16'd0, 16'h0505);
        write_imem(16'd1, 16'h030F);
        write_imem(16'd3, 16'hA003);
        write_imem(16'd32, 16'hA020);
        fetch(1'b0, 16'd0);
        check("fetch addr0", ins_out, 16'h0505);
        fetch(1'b0, 16'd1);
        check("fetch addr1", ins_out, 16'h030F);

        // Same-address write and read on one edge returns old data.
        write_imem(16'd2, 16'h1111);
        clear_ctrl();
        writeins = 1; readins = 1; TopID = 0; insadd_line = 16'd2; inswrite_line = 16'h2222;
        tick();
        check("imem rw old", ins_out, 16'h1111);
        fetch(1'b0, 16'd2);
        check("imem rw new", ins_out, 16'h2222);

        // Sign extenders.
        set_ir(16'h06F7);
        check("ir 06F7", ins_out, 16'h06F7);
        TransY3 = 1; TransYZ = 1; write = 1;
        tick();
        read_reg(3'd6, v);
        check("sext11", v, 16'hFEF7);
        set_ir(16'h06F7);
        TransY2 = 1; TransYZ = 1; write = 1;
        tick();
        read_reg(3'd6, v);
        check("sext8", v, 16'hFFF7);
        set_ir(16'h06F7);
        TransX3 = 1; func_select = ALU_ADD; Trans_ALU_Z = 1; write = 1;
        tick();
        read_reg(3'd6, v);
        check("sext5", v, 16'hFFF7);
        set_ir(16'h06F7);
        TransX1 = 1; TransX3 = 1;
        #1 check("x priority X1 over X3", flags(), 16'h0001);
        TransX1 = 0;
        #1 check("x from sext5 flags", flags(), 16'h0002);
        clear_ctrl();
        set_ir(16'h00AB);
        TransY2 = 1; TransYZ = 1; write = 1;
        tick();
        read_reg(3'd0, v);
        check("sext8 00AB", v, 16'hFFAB);

        // Register path, including write-and-read of the same register.
        load_imm8(3'd1, 8'h0F);
        alu_rr(3'd3, 3'd1, 3'd1, ALU_ADD, fl);
        check("reg add flags", fl, 16'h0000);
        read_reg(3'd3, v);
        check("reg add result", v, 16'h001E);
        alu_rr(3'd1, 3'd1, 3'd1, ALU_ADD, fl);
        alu_rr(3'd2, 3'd1, 3'd1, ALU_ADD, fl);
        read_reg(3'd2, v);
        check("reg rw next cycle", v, 16'h003C);

        // Data memory write at X=5, then read through TDZ with and without readData.
        load_const(3'd1, 16'hBEEF);
        set_ir(16'h0005);
        TransX3 = 1; read2 = 1; TransY1 = 1; writeData = 1;
        tick();
        clear_ctrl();
        set_ir(16'h0205);
        TransX3 = 1; readData = 1; TDZ = 1; write = 1;
        tick();
        read_reg(3'd2, v);
        check("dmem read", v, 16'hBEEF);
        load_imm8(3'd2, 8'h55);
        set_ir(16'h0205);
        TransX3 = 1; TDZ = 1; write = 1;
        tick();
        read_reg(3'd2, v);
        check("dmem read disabled", v, 16'h0000);

        // PC increment, load from Z, hold, and fetch via PC.
        fetch(1'b1, 16'd0);
        check("pc after reset", ins_out, 16'h0505);
        clear_ctrl();
        ldPC = 1; Trans1PC = 1;
        repeat (3) tick();
        fetch(1'b1, 16'd0);
        check("pc inc x3", ins_out, 16'hA003);
        set_ir(16'h0020);
        TransY2 = 1; TransYZ = 1; ldPC = 1; Trans2PC = 1;
        tick();
        fetch(1'b1, 16'd0);
        check("pc from z", ins_out, 16'hA020);
        clear_ctrl();
        Trans1PC = 1;
        tick();
        fetch(1'b1, 16'd0);
        check("pc hold", ins_out, 16'hA020);

        // Asynchronous reset mid-run.
        #2 rst = 0;
        #1 check("async reset ir", ins_out, 16'h0000);
        #1 rst = 1;
        tick();
        fetch(1'b1, 16'd0);
        check("pc after async reset", ins_out, 16'h0505);
        read_reg(3'd1, v);
        check("reg after async reset", v, 16'h0000);

        // PC wrap from 0xFFFF to 0.
        set_ir(16'h00FF);
        TransY2 = 1; TransYZ = 1; ldPC = 1; Trans2PC = 1;
        tick();
        clear_ctrl();
        ldPC = 1; Trans1PC = 1;
        tick();
        fetch(1'b1, 16'd0);
        check("pc wrap", ins_out, 16'h0505);

        // ALU vector table over register operands.
        for (int i = 0; i < 15; i++) begin
            load_const(3'd1, vecs[i].x);
            load_const(3'd2, vecs[i].y);
            alu_rr(3'd3, 3'd1, 3'd2, vecs[i].f, fl);
            check($sformatf("vec%0d flags", i), fl, {12'h000, vecs[i].cvsz});
            read_reg(3'd3, v);
            check($sformatf("vec%0d z", i), v, vecs[i].z);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_code.md
Name: datapath_code

Overview:
- 16-bit single-cycle CPU datapath: instruction memory with instruction register, PC, 8x16 register file, three-bus fabric (X, Y, Z), 16-bit ALU, 5/8/11-bit sign extenders and data memory.
- Every transfer is steered by discrete control strobes from an external controller.
- Raw ALU flags are exported combinationally for the controller's flag register.

Parameters:
- IMEM_DEPTH, 64, instruction memory words; address = low log2(IMEM_DEPTH) bits.
- DMEM_DEPTH, 64, data memory words; address = low log2(DMEM_DEPTH) bits.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- rst in 1: reset, asynchronous, active-low (rst=0 resets).
- inswrite_line in 16: instruction word to load.
- insadd_line in 16: external instruction memory address.
- readins in 1: load IR from instruction memory.
- writeins in 1: write instruction memory.
- TopID in 1: IR fetch address select, 1=PC, 0=insadd_line.
- Trans1PC in 1: PC source = PC+1.
- Trans2PC in 1: PC source = Z bus.
- ldPC in 1: PC load enable.
- read1 in 1: enable register file port A.
- read2 in 1: enable register file port B.
- write in 1: register file write enable.
- TransX1, TransX2, TransX3 in 1 each: X bus drivers.
- TransY1, TransY2, TransY3 in 1 each: Y bus drivers.
- func_select in 3: ALU operation.
- Trans_ALU_Z, TransYZ, TDZ in 1 each: Z bus drivers.
- readData in 1: data memory read enable.
- writeData in 1: data memory write enable.
- ins_out out 16: instruction register.
- Zin out 1: ALU zero flag.
- Vin out 1: ALU overflow flag.
- Sin out 1: ALU sign flag.
- Cin out 1: ALU carry flag.

Behaviour:
- Reset (rst=0, async): PC=0, IR=0, R0..R7=0; memories are not cleared. Flags follow the ALU combinationally.
- Instruction fields: rd=ins_out[10:8], rs1=ins_out[7:5], rs2=ins_out[4:2]. sext5=ins_out[4:0], sext8=ins_out[7:0], sext11=ins_out[10:0], each replicating its MSB to 16 bits.
- Instruction memory: on the edge, writeins writes imem[insadd_line] <= inswrite_line. On the same edge, readins loads IR <= imem[TopID ? PC : insadd_line]. Same-address read and write on one edge returns old data.
- Register file reads are combinational: A = read1 ? R[rs1] : 0; B = read2 ? R[rs2] : 0. On the edge, write sets R[rd] <= Z.
- X bus, priority X1 > X2 > X3, otherwise 0: TransX1 = A, TransX2 = PC, TransX3 = sext5.
- Y bus, priority Y1 > Y2 > Y3, otherwise 0: TransY1 = B, TransY2 = sext8, TransY3 = sext11.
- ALU, combinational on X and Y:
  - 000 add X+Y; 001 sub X-Y (computed as X + ~Y + 1).
  - 010 AND; 011 OR; 100 XOR; 101 NOT X.
  - 110 X<<1; 111 X>>1 (logical).
- Flags:
  - Cin: add/sub = bit-16 carry-out; shifts = bit shifted out; logic ops = 0.
  - Vin: add/sub = two's-complement overflow; otherwise 0.
  - Zin = (result == 0); Sin = result[15].
- Z bus, priority Trans_ALU_Z > TransYZ > TDZ, otherwise 0: Trans_ALU_Z = ALU result, TransYZ = Y bus, TDZ = data memory output.
- Data memory: address = X bus. Output = readData ? dmem[addr] : 0, combinational. On the edge, writeData sets dmem[addr] <= Y.
- PC: on the edge when ldPC=1, PC <= Trans1PC ? PC+1 : (Trans2PC ? Z : PC). PC wraps from 0xFFFF to 0.
- Simultaneous write and read of the same register: the read returns the old value and the new value is visible next cycle.

Decomposition:
- Package dp_pkg: ALU function codes (ALU_ADD=3'b000 through ALU_SHR=3'b111), WORD_W=16, REG_ADDR_W=3.
- One sub-module alu16: func, x, y -> z, carry, overflow.
- Sign extenders, buses and memories stay inline.

Test Plan:
- Load imem: writeins=1, insadd_line=0, inswrite_line=16'h0505, then addr 1 = 16'h030F. Fetch with readins=1, TopID=0 -> ins_out=16'h0505, then 16'h030F.
- ALU via the immediate paths:
  - X=0x0008, Y=0x0001, func 000 -> Z=0x0009, C=0, V=0.
  - X=0x0419, Y=0x0001, func 001 -> Z=0x0418, C=1.
  - X=0x7FFF, Y=0x0001, add -> Z=0x8000, V=1, S=1.
  - X=Y=0x1234, sub -> Zin=1.
- Sign extension: ins_out=16'h06F7 -> sext11=16'hFEF7, sext8=16'hFFF7, sext5=16'hFFF7. ins_out=16'h00AB -> sext8=16'hFFAB.
- Register path: ins_out rd=1, TransY2=1, TransYZ=1, write=1 with imm 0x0F -> R1=0x000F next cycle. Then read1 with rs1=1, TransX1=1, ADD with Y=sext8 -> Z=0x001E.
- PC: after reset PC=0. ldPC=1, Trans1PC=1 for 3 edges -> PC=3. Trans2PC=1 with Z=0x0020 -> PC=0x0020. rst=0 mid-run -> PC=0 immediately, without waiting for a clock edge.
- Data memory: X=5, Y=0xBEEF, writeData=1 for one edge. Then readData=1, TDZ=1 -> Z=0xBEEF. With readData=0 -> Z=0.
